multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Moore FSM that sequences the shared multi-cycle MIPS datapath (single memory, single ALU, IR/MDR/A/B/ALUOut registers).
Decodes opcode/funct from the instruction register and drives mux selects and write enables each cycle.
Memory accesses wait on a ready handshake.
Supports R-type (incl. NOP), ANDI, LW, SW, BEQ, J, JR.

Parameters:
CNT_W, 32, width of performance counters (used only when MC_PERF_CNT_EN is defined)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
OpCode  in  6  IR[31:26]
Funct  in  6  IR[5:0]
mem_ready  in  1  memory completes access this cycle
PCWrite  out  1  unconditional PC write
PCWriteCond  out  1  PC write qualified by ALU zero (datapath ANDs)
IorD  out  1  0=PC, 1=ALUOut as memory address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load IR (and PC+4 into PC via PCWrite)
RegDst  out  1  0=rt, 1=rd
MemtoReg  out  1  0=ALUOut, 1=MDR
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=const 4, 10=ext imm, 11=sign-ext imm<<2
ALUOp  out  2  00=add, 01=sub, 10=funct, 11=and
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A (rs)
ExtendSel  out  1  1=sign extend, 0=zero extend
illegal  out  1  sticky unimplemented-opcode flag
state_o  out  4  current state encoding (debug)
cycle_cnt, instr_cnt  out  CNT_W  present only with MC_PERF_CNT_EN

Behaviour:
- Single clock; reset synchronous active-high. rst=1 at a posedge: state<=FETCH, illegal<=0, counters<=0.
- While rst=1, PCWrite, PCWriteCond, IRWrite, RegWrite and MemWrite are forced 0.
- Outputs decode from the state register only (Moore). Exception: FETCH gates IRWrite/PCWrite with mem_ready.
- Default in every state: all enables 0, all selects 0, ExtendSel=1. The state list below gives only non-default outputs.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready. mem_ready=1 -> DECODE, else hold.
- DECODE: ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state:
  - LW/SW -> MEMADR
  - R-type with Funct=001000 -> JREX
  - other R-type -> RTEX
  - ANDI -> ANDIEX
  - BEQ -> BEQEX
  - J -> JEX
  - else -> ILLEGAL
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEMRD, SW -> MEMWR.
- MEMRD: IorD=1, MemRead=1. Hold until mem_ready, then -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1. Hold until mem_ready, then -> FETCH. MemWrite stays asserted for every wait cycle.
- RTEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB: RegDst=1, RegWrite=1 -> FETCH.
- ANDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=11, ExtendSel=0 -> IMMWB.
- IMMWB: RegDst=0, RegWrite=1 -> FETCH.
- BEQEX: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JEX: PCWrite=1, PCSource=10 -> FETCH.
- JREX: PCWrite=1, PCSource=11 -> FETCH.
- ILLEGAL: illegal=1; no enables asserted; terminal until rst.
- Latency with zero wait states:
  - BEQ/J/JR: 3 cycles
  - R-type/ANDI/SW: 4 cycles
  - LW: 5 cycles
  - Each memory state adds one cycle per mem_ready=0 cycle.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR. OpCode/Funct are sampled in DECODE and MEMADR only.
- Reset during a memory wait aborts the access; the next cycle is FETCH.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on each transition into FETCH from any state other than FETCH (retire).
  - Both wrap modulo 2^CNT_W.
  - Both freeze in ILLEGAL.
- Undefined: counters and their ports are absent; behaviour otherwise identical.

Decomposition:
- Package mc_pkg holds:
  - state enum (4-bit)
  - opcode constants R_TYPE, ANDI, LW, SW, BEQ, J and Funct_JR
  - ALUOp encodings
  - ALUSrcB encodings
  - PCSource encodings
- Sub-module mc_perf_counter (the two counters) is instantiated only under MC_PERF_CNT_EN.

Test Plan:
- rst=1 for 2 cycles with state in MEMRD -> state_o=FETCH, illegal=0, no write enables during reset; MemRead=1 next cycle.
- LW (OpCode=100011), mem_ready always 1 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; RegWrite=1 and MemtoReg=1 only in cycle 5.
- SW with mem_ready low 3 cycles in MEMWR -> MemWrite high 4 consecutive cycles; return to FETCH after the ready cycle; 7 cycles total.
- BEQ then JR (OpCode=0, Funct=001000) -> PCWriteCond=1, PCSource=01 in cycle 3; next instruction PCWrite=1, PCSource=11 in cycle 3; RegWrite never asserted.
- ANDI -> ANDIEX: ALUOp=11, ExtendSel=0; IMMWB: RegWrite=1, RegDst=0.
- OpCode=111111 -> ILLEGAL; illegal=1 held 10 cycles with mem_ready toggling; cleared by rst. With MC_PERF_CNT_EN, instr_cnt is unchanged.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM:
// state enum, opcode/funct constants, mux-select encodings, opcode decoder.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTEX    = 4'd6,
        ALUWB   = 4'd7,
        ANDIEX  = 4'd8,
        IMMWB   = 4'd9,
        BEQEX   = 4'd10,
        JEX     = 4'd11,
        JREX    = 4'd12,
        ILLEGAL = 4'd13
    } state_e;

    localparam logic [5:0] R_TYPE   = 6'b000000;
    localparam logic [5:0] ANDI     = 6'b001100;
    localparam logic [5:0] LW       = 6'b100011;
    localparam logic [5:0] SW       = 6'b101011;
    localparam logic [5:0] BEQ      = 6'b000100;
    localparam logic [5:0] J        = 6'b000010;
    localparam logic [5:0] Funct_JR = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    // First execute state for the instruction held in IR.
    function automatic state_e decode_op(input logic [5:0] op,
                                         input logic [5:0] fn);
        state_e s;
        s = ILLEGAL;
        unique case (1'b1)
            (op == LW) || (op == SW):         s = MEMADR;
            (op == R_TYPE) && (fn == Funct_JR): s = JREX;
            (op == R_TYPE) && (fn != Funct_JR): s = RTEX;
            (op == ANDI):                     s = ANDIEX;
            (op == BEQ):                      s = BEQEX;
            (op == J):                        s = JEX;
            default:                          s = ILLEGAL;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mc_perf_counter.sv
// Free-running cycle and retired-instruction counters (wrap modulo 2^CNT_W).
// Ports: clk_i, rst_i (sync, active-high), tick_i, retire_i, cycle_cnt_o, instr_cnt_o.
module mc_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             retire_i,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ins_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            if (tick_i)
                cyc_q <= cyc_q + CNT_W'(1);
            if (retire_i)
                ins_q <= ins_q + CNT_W'(1);
        end
    end

    assign cycle_cnt_o = cyc_q;
    assign instr_cnt_o = ins_q;

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the shared-memory multi-cycle MIPS datapath.
// Ports: clk, rst (sync active-high), OpCode, Funct, mem_ready in; datapath
// enables/selects, sticky illegal flag and state_o out. Optional perf
// counters (cycle_cnt, instr_cnt) exist only when MC_PERF_CNT_EN is defined.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             ExtendSel,
    output logic             illegal,
    output logic [3:0]       state_o
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_e state_q, state_d;
    logic   illegal_q;

    logic pc_write, pc_write_cond, mem_write, ir_write, reg_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == ILLEGAL);
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        reg_write     = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_B;
        ALUOp         = ALU_ADD;
        PCSource      = PCSRC_ALU;
        ExtendSel     = 1'b1;
        unique case (state_q)
            FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                // IR load and PC+4 only when the fetch completes
                ir_write = mem_ready;
                pc_write = mem_ready;
                if (mem_ready)
                    state_d = DECODE;
            end
            DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
                state_d = decode_op(OpCode, Funct);
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                if (OpCode == LW)
                    state_d = MEMRD;
                else if (OpCode == SW)
                    state_d = MEMWR;
                else
                    state_d = ILLEGAL;
            end
            MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready)
                    state_d = MEMWB;
            end
            MEMWB: begin
                MemtoReg  = 1'b1;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            MEMWR: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready)
                    state_d = FETCH;
            end
            RTEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegDst    = 1'b1;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            ANDIEX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                ALUOp     = ALU_AND;
                ExtendSel = 1'b0;
                state_d   = IMMWB;
            end
            IMMWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BEQEX: begin
                ALUSrcA       = 1'b1;
                ALUOp         = ALU_SUB;
                pc_write_cond = 1'b1;
                PCSource      = PCSRC_ALUOUT;
                state_d       = FETCH;
            end
            JEX: begin
                pc_write = 1'b1;
                PCSource = PCSRC_JUMP;
                state_d  = FETCH;
            end
            JREX: begin
                pc_write = 1'b1;
                PCSource = PCSRC_RS;
                state_d  = FETCH;
            end
            ILLEGAL: begin
                state_d = ILLEGAL;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Architectural writes are suppressed while reset is held.
    assign PCWrite     = pc_write & ~rst;
    assign PCWriteCond = pc_write_cond & ~rst;
    assign IRWrite     = ir_write & ~rst;
    assign RegWrite    = reg_write & ~rst;
    assign MemWrite    = mem_write & ~rst;

    assign illegal = illegal_q;
    assign state_o = state_q;

`ifdef MC_PERF_CNT_EN
    logic tick, retire;

    assign tick   = (state_q != ILLEGAL);
    assign retire = tick && (state_q != FETCH) && (state_d == FETCH);

    mc_perf_counter #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk_i      (clk),
        .rst_i      (rst),
        .tick_i     (tick),
        .retire_i   (retire),
        .cycle_cnt_o(cycle_cnt),
        .instr_cnt_o(instr_cnt)
    );
`else
    logic [31:0] unused_cnt_w;
    assign unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised bench for multicycle_control: per-instruction expected
// cycle sequences are expanded from instruction class and wait counts.
module tb_multicycle_control;
    import mc_pkg::*;

    localparam int CNT_W = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] OpCode, Funct;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA, ExtendSel, illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_o;
`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct),
        .mem_ready(mem_ready), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .ExtendSel(ExtendSel), .illegal(illegal), .state_o(state_o)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    // Control word bit positions (MSB first):
    // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite RegDst MemtoReg
    // RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0] ExtendSel
    localparam logic [16:0] K_PCW  = 17'h10000;
    localparam logic [16:0] K_PCC  = 17'h08000;
    localparam logic [16:0] K_IORD = 17'h04000;
    localparam logic [16:0] K_MRD  = 17'h02000;
    localparam logic [16:0] K_MWR  = 17'h01000;
    localparam logic [16:0] K_IRW  = 17'h00800;
    localparam logic [16:0] K_RDST = 17'h00400;
    localparam logic [16:0] K_M2R  = 17'h00200;
    localparam logic [16:0] K_RW   = 17'h00100;
    localparam logic [16:0] K_SRCA = 17'h00080;
    localparam logic [16:0] K_EXT  = 17'h00001;

    localparam logic [16:0] W_FWAIT = K_MRD | (17'd1 << 5) | K_EXT;
    localparam logic [16:0] W_FGO   = W_FWAIT | K_IRW | K_PCW;
    localparam logic [16:0] W_DEC   = (17'd3 << 5) | K_EXT;
    localparam logic [16:0] W_MADR  = K_SRCA | (17'd2 << 5) | K_EXT;
    localparam logic [16:0] W_MRD   = K_IORD | K_MRD | K_EXT;
    localparam logic [16:0] W_MWB   = K_M2R | K_RW | K_EXT;
    localparam logic [16:0] W_MWR   = K_IORD | K_MWR | K_EXT;
    localparam logic [16:0] W_RTX   = K_SRCA | (17'd2 << 3) | K_EXT;
    localparam logic [16:0] W_AWB   = K_RDST | K_RW | K_EXT;
    localparam logic [16:0] W_ANX   = K_SRCA | (17'd2 << 5) | (17'd3 << 3);
    localparam logic [16:0] W_IWB   = K_RW | K_EXT;
    localparam logic [16:0] W_BQX   = K_SRCA | (17'd1 << 3) | K_PCC
                                    | (17'd1 << 1) | K_EXT;
    localparam logic [16:0] W_JX    = K_PCW | (17'd2 << 1) | K_EXT;
    localparam logic [16:0] W_JRX   = K_PCW | (17'd3 << 1) | K_EXT;
    localparam logic [16:0] W_ILL   = K_EXT;

    typedef struct {
        state_e      st;
        logic        rdy;
        logic [16:0] w;
        logic        ill;
    } ent_t;

    ent_t seq[$];
    int   n_run  = 0;
    int   n_fail = 0;
    int   exp_cyc = 0;
    int   exp_ins = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] ctrl_word();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                PCSource, ExtendSel};
    endfunction

    function automatic void push(state_e s, logic r, logic [16:0] w,
                                 logic ill);
        ent_t e;
        e.st = s; e.rdy = r; e.w = w; e.ill = ill;
        seq.push_back(e);
    endfunction

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction.
    function automatic void build(logic [5:0] op, logic [5:0] fn,
                                  int wf, int wm);
        seq.delete();
        for (int i = 0; i < wf; i++) push(FETCH, 1'b0, W_FWAIT, 1'b0);
        push(FETCH, 1'b1, W_FGO, 1'b0);
        push(DECODE, rnd1(), W_DEC, 1'b0);
        if (op == 6'b100011) begin
            push(MEMADR, rnd1(), W_MADR, 1'b0);
            for (int i = 0; i < wm; i++) push(MEMRD, 1'b0, W_MRD, 1'b0);
            push(MEMRD, 1'b1, W_MRD, 1'b0);
            push(MEMWB, rnd1(), W_MWB, 1'b0);
        end else if (op == 6'b101011) begin
            push(MEMADR, rnd1(), W_MADR, 1'b0);
            for (int i = 0; i < wm; i++) push(MEMWR, 1'b0, W_MWR, 1'b0);
            push(MEMWR, 1'b1, W_MWR, 1'b0);
        end else if (op == 6'b000000 && fn == 6'b001000) begin
            push(JREX, rnd1(), W_JRX, 1'b0);
        end else if (op == 6'b000000) begin
            push(RTEX, rnd1(), W_RTX, 1'b0);
            push(ALUWB, rnd1(), W_AWB, 1'b0);
        end else if (op == 6'b001100) begin
            push(ANDIEX, rnd1(), W_ANX, 1'b0);
            push(IMMWB, rnd1(), W_IWB, 1'b0);
        end else if (op == 6'b000100) begin
            push(BEQEX, rnd1(), W_BQX, 1'b0);
        end else if (op == 6'b000010) begin
            push(JEX, rnd1(), W_JX, 1'b0);
        end else begin
            // illegal: hold 10 cycles with mem_ready toggling
            for (int i = 0; i < 10; i++)
                push(ILLEGAL, 1'(i), W_ILL, 1'b1);
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 after the last cycle run.
    task automatic run(input logic [5:0] op, input logic [5:0] fn,
                       input int wf, input int wm, input int limit);
        int   n;
        ent_t e;
        build(op, fn, wf, wm);
        n = seq.size();
        if (limit >= 0 && limit < n) n = limit;
        for (int i = 0; i < n; i++) begin
            e = seq[i];
            mem_ready = e.rdy;
            if (e.st == DECODE || e.st == MEMADR) begin
                OpCode = op;
                Funct  = fn;
            end else begin
                OpCode = 6'($urandom);
                Funct  = 6'($urandom);
            end
            @(negedge clk);
            check($sformatf("op%02h state@%0d", op, i),
                  32'(state_o), 32'(e.st));
            check($sformatf("op%02h ctrl@%0d", op, i),
                  32'(ctrl_word()), 32'(e.w));
            check($sformatf("op%02h illegal@%0d", op, i),
                  32'(illegal), 32'(e.ill));
`ifdef MC_PERF_CNT_EN
            check($sformatf("op%02h cycle_cnt@%0d", op, i),
                  cycle_cnt, 32'(exp_cyc));
            check($sformatf("op%02h instr_cnt@%0d", op, i),
                  instr_cnt, 32'(exp_ins));
`endif
            if (!e.ill) exp_cyc++;
            if (i == seq.size() - 1 && !e.ill) exp_ins++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        OpCode = 6'($urandom);
        Funct  = 6'($urandom);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("rst writes@%0d", i),
                  32'({PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite}),
                  32'd0);
            if (i == 1) begin
                check("rst state", 32'(state_o), 32'(FETCH));
                check("rst illegal", 32'(illegal), 32'd0);
`ifdef MC_PERF_CNT_EN
                check("rst cycle_cnt", cycle_cnt, 32'd0);
                check("rst instr_cnt", instr_cnt, 32'd0);
`endif
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        exp_cyc = 0;
        exp_ins = 0;
    endtask

    initial begin
        logic [5:0] op, fn;
        int         k;
        rst = 1'b1;
        mem_ready = 1'b0;
        OpCode = '0;
        Funct  = '0;
        @(posedge clk);
        #1;
        do_reset();

        run(6'b100011, 6'h15, 0, 0, -1);
        run(6'b101011, 6'h2a, 0, 3, -1);
        run(6'b000100, 6'h00, 0, 0, -1);
        run(6'b000000, 6'b001000, 0, 0, -1);
        run(6'b001100, 6'h3f, 0, 0, -1);
        run(6'b000010, 6'h11, 2, 0, -1);
        run(6'b000000, 6'b000000, 0, 0, -1);

        // reset in the middle of a load wait, then of a store wait
        run(6'b100011, 6'h00, 1, 3, 5);
        do_reset();
        run(6'b101011, 6'h00, 0, 3, 5);
        do_reset();

        for (int i = 0; i < 80; i++) begin
            k  = int'($urandom_range(0, 7));
            fn = 6'($urandom);
            case (k)
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: begin
                    op = 6'b000000;
                    if (fn == 6'b001000) fn = 6'b100000;
                end
                3: begin op = 6'b000000; fn = 6'b000000; end
                4: op = 6'b001100;
                5: op = 6'b000100;
                6: op = 6'b000010;
                default: begin op = 6'b000000; fn = 6'b001000; end
            endcase
            run(op, fn, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), -1);
        end

        run(6'b111111, 6'h00, 1, 0, -1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do begin
                op = 6'($urandom);
            end while (op == 6'h00 || op == 6'h0c || op == 6'h23 ||
                       op == 6'h2b || op == 6'h04 || op == 6'h02);
            run(6'b001100, 6'h01, 0, 0, -1);
            run(op, 6'($urandom), int'($urandom_range(0, 2)), 0, -1);
            do_reset();
        end
        run(6'b100011, 6'h00, 0, 1, -1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
